// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and ExcCode constants for the exception sequencer
//
// Purpose: ExcCode values, sequencer state enum, event record struct and
// small helpers used by exc_prio and exc_seq.
// Ports: none (package).
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } exc_state_t;

  typedef enum logic [1:0] {
    KIND_EXC,
    KIND_INT,
    KIND_ERET
  } exc_kind_t;

  typedef struct packed {
    exc_kind_t   kind;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badv;
    logic [31:0] epc;
  } exc_rec_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] pc);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // Only address errors carry a meaningful faulting address.
  function automatic logic has_badv(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_seq_if.sv
// rtl/exc_seq_if.sv - M-stage, CP0 and redirect signal bundle of the exception sequencer
//
// Purpose: groups every non-clock/reset signal of exc_seq.
// Modports:
//   master - the sequencer: consumes M-stage/CP0/bus status, drives
//            stall/flush, CP0 commit record and the fetch redirect.
//   slave  - the surrounding pipeline: the mirror image.
interface exc_seq_if;

  logic        m_valid;
  logic        exc_valid_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        bd_m;
  logic [31:0] pc_m;
  logic [31:0] badvaddr_m;
  logic        int_pending;
  logic [31:0] epc_in;
  logic        ibus_busy;
  logic        dbus_busy;
  logic        redirect_ready;

  logic        stall_all;
  logic        flush_all;
  logic        cp0_we;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic        cp0_badv_we;
  logic [31:0] cp0_badvaddr;
  logic        cp0_eret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    input  m_valid, exc_valid_m, exc_code_m, eret_m, bd_m, pc_m, badvaddr_m,
           int_pending, epc_in, ibus_busy, dbus_busy, redirect_ready,
    output stall_all, flush_all, cp0_we, cp0_exc_code, cp0_epc, cp0_bd,
           cp0_badv_we, cp0_badvaddr, cp0_eret, redirect_valid, redirect_pc
  );

  modport slave (
    output m_valid, exc_valid_m, exc_code_m, eret_m, bd_m, pc_m, badvaddr_m,
           int_pending, epc_in, ibus_busy, dbus_busy, redirect_ready,
    input  stall_all, flush_all, cp0_we, cp0_exc_code, cp0_epc, cp0_bd,
           cp0_badv_we, cp0_badvaddr, cp0_eret, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/exc_prio.sv
// rtl/exc_prio.sv - combinational event priority selector for the M-stage instruction
//
// Purpose: decides whether the M-stage slot raises an event and builds its
// record. Priority: interrupt > synchronous exception > ERET.
// Ports:
//   m_valid, exc_valid_m, exc_code_m, eret_m, bd_m, pc_m, badvaddr_m,
//   int_pending, epc_in  in   M-stage and CP0 status
//   ev_valid             out  an event is present this cycle
//   rec                  out  record describing the selected event
module exc_prio
  import exc_pkg::*;
(
  input  logic        m_valid,
  input  logic        exc_valid_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic        bd_m,
  input  logic [31:0] pc_m,
  input  logic [31:0] badvaddr_m,
  input  logic        int_pending,
  input  logic [31:0] epc_in,
  output logic        ev_valid,
  output exc_rec_t    rec
);

  always_comb begin
    ev_valid = m_valid & (int_pending | exc_valid_m | eret_m);
    rec.bd   = bd_m;
    rec.pc   = pc_m;
    rec.badv = badvaddr_m;
    rec.epc  = epc_in;
    if (int_pending) begin
      rec.kind = KIND_INT;
      rec.code = EXC_INT;
    end else if (exc_valid_m) begin
      // An exception on the same instruction as ERET discards the ERET.
      rec.kind = KIND_EXC;
      rec.code = exc_code_m;
    end else begin
      rec.kind = KIND_ERET;
      rec.code = EXC_INT;
    end
  end

endmodule

// File: rtl/exc_seq.sv
// rtl/exc_seq.sv - exception sequencer between the M stage and CP0
//
// Purpose: on an exception/interrupt/ERET in M, freezes the pipeline, waits
// for bus drain, commits the record to CP0 for one cycle, then flushes and
// redirects fetch under a valid/ready handshake.
// Ports:
//   clk     in  clock
//   resetn  in  synchronous active-low reset
//   bus     exc_seq_if.master: M-stage inputs, CP0 commit outputs, redirect
// Parameters:
//   EXC_VECTOR  exception entry PC
module exc_seq
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic       clk,
  input  logic       resetn,
  exc_seq_if.master  bus
);

  logic       ev_valid;
  exc_rec_t   ev_rec;

  exc_state_t  state;
  exc_rec_t    rec_q;
  logic [31:0] epc_q;
  logic        stall_q;
  logic        flush_q;
  logic        we_q;
  logic        eret_q;
  logic        badv_we_q;
  logic        rv_q;
  logic [31:0] rpc_q;

  // Record that COMMIT will use: fresh from the selector when skipping
  // DRAIN, otherwise the one latched at detection.
  exc_rec_t   commit_src;
  logic       busy;

  exc_prio u_prio (
    .m_valid     (bus.m_valid),
    .exc_valid_m (bus.exc_valid_m),
    .exc_code_m  (bus.exc_code_m),
    .eret_m      (bus.eret_m),
    .bd_m        (bus.bd_m),
    .pc_m        (bus.pc_m),
    .badvaddr_m  (bus.badvaddr_m),
    .int_pending (bus.int_pending),
    .epc_in      (bus.epc_in),
    .ev_valid    (ev_valid),
    .rec         (ev_rec)
  );

  assign commit_src = (state == ST_IDLE) ? ev_rec : rec_q;
  assign busy       = bus.ibus_busy | bus.dbus_busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      rec_q     <= '0;
      epc_q     <= '0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      we_q      <= 1'b0;
      eret_q    <= 1'b0;
      badv_we_q <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_valid) begin
            rec_q   <= ev_rec;
            epc_q   <= epc_of(ev_rec.bd, ev_rec.pc);
            stall_q <= 1'b1;
            state   <= busy ? ST_DRAIN : ST_COMMIT;
            if (!busy) begin
              flush_q   <= 1'b1;
              we_q      <= (commit_src.kind != KIND_ERET);
              eret_q    <= (commit_src.kind == KIND_ERET);
              badv_we_q <= (commit_src.kind == KIND_EXC) & has_badv(commit_src.code);
            end
          end
        end
        ST_DRAIN: begin
          if (!busy) begin
            state     <= ST_COMMIT;
            flush_q   <= 1'b1;
            we_q      <= (commit_src.kind != KIND_ERET);
            eret_q    <= (commit_src.kind == KIND_ERET);
            badv_we_q <= (commit_src.kind == KIND_EXC) & has_badv(commit_src.code);
          end
        end
        ST_COMMIT: begin
          we_q      <= 1'b0;
          eret_q    <= 1'b0;
          badv_we_q <= 1'b0;
          rv_q      <= 1'b1;
          rpc_q     <= (rec_q.kind == KIND_ERET) ? rec_q.epc : EXC_VECTOR;
          state     <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The only combinational path: freeze in the detection cycle itself.
  assign bus.stall_all      = stall_q | ((state == ST_IDLE) & ev_valid);
  assign bus.flush_all      = flush_q;
  assign bus.cp0_we         = we_q;
  assign bus.cp0_eret       = eret_q;
  assign bus.cp0_badv_we    = badv_we_q;
  assign bus.cp0_exc_code   = rec_q.code;
  assign bus.cp0_bd         = rec_q.bd;
  assign bus.cp0_epc        = epc_q;
  assign bus.cp0_badvaddr   = rec_q.badv;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_seq.sv
// tb/tb_exc_seq.sv - directed self-checking bench for exc_seq
module tb_exc_seq;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;
  int   we_seen;

  exc_seq_if bus ();

  exc_seq #(.EXC_VECTOR(32'hbfc00380)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.m_valid     = 1'b0;
    bus.exc_valid_m = 1'b0;
    bus.exc_code_m  = 5'h00;
    bus.eret_m      = 1'b0;
    bus.bd_m        = 1'b0;
    bus.pc_m        = 32'h0;
    bus.badvaddr_m  = 32'h0;
    bus.int_pending = 1'b0;
    bus.epc_in      = 32'h0;
    bus.ibus_busy   = 1'b0;
    bus.dbus_busy   = 1'b0;
  endtask

  task automatic exc_ev(input logic [4:0] code, input logic bd, input logic [31:0] pc);
    bus.m_valid     = 1'b1;
    bus.exc_valid_m = 1'b1;
    bus.exc_code_m  = code;
    bus.bd_m        = bd;
    bus.pc_m        = pc;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    clear_in();
    bus.redirect_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_stall", bus.stall_all, 0);
    chk("rst_flush", bus.flush_all, 0);
    chk("rst_we", bus.cp0_we, 0);
    chk("rst_eret", bus.cp0_eret, 0);
    chk("rst_badv_we", bus.cp0_badv_we, 0);
    chk("rst_rv", bus.redirect_valid, 0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk("rst_epc", bus.cp0_epc, 32'h0);
    resetn = 1'b1;
    tick();

    // Overflow, buses idle
    exc_ev(5'h0c, 1'b0, 32'hbfc00100);
    #1;
    chk("ov_t_stall", bus.stall_all, 1);
    chk("ov_t_we", bus.cp0_we, 0);
    tick(); clear_in(); #1;
    chk("ov_c_we", bus.cp0_we, 1);
    chk("ov_c_code", bus.cp0_exc_code, 32'h0c);
    chk("ov_c_epc", bus.cp0_epc, 32'hbfc00100);
    chk("ov_c_bd", bus.cp0_bd, 0);
    chk("ov_c_badv_we", bus.cp0_badv_we, 0);
    chk("ov_c_flush", bus.flush_all, 1);
    chk("ov_c_rv", bus.redirect_valid, 0);
    tick(); #1;
    chk("ov_r_we", bus.cp0_we, 0);
    chk("ov_r_rv", bus.redirect_valid, 1);
    chk("ov_r_rpc", bus.redirect_pc, 32'hbfc00380);
    chk("ov_r_stall", bus.stall_all, 1);
    tick(); #1;
    chk("ov_i_rv", bus.redirect_valid, 0);
    chk("ov_i_stall", bus.stall_all, 0);
    chk("ov_i_flush", bus.flush_all, 0);

    // AdEL in delay slot with three drain cycles
    exc_ev(5'h04, 1'b1, 32'hbfc00204);
    bus.badvaddr_m = 32'h00000003;
    bus.dbus_busy  = 1'b1;
    #1;
    chk("adel_t_stall", bus.stall_all, 1);
    tick(); clear_in(); bus.dbus_busy = 1'b1; #1;
    chk("adel_d1_stall", bus.stall_all, 1);
    chk("adel_d1_we", bus.cp0_we, 0);
    chk("adel_d1_flush", bus.flush_all, 0);
    tick(); #1;
    chk("adel_d2_we", bus.cp0_we, 0);
    tick(); bus.dbus_busy = 1'b0; #1;
    chk("adel_d3_stall", bus.stall_all, 1);
    chk("adel_d3_we", bus.cp0_we, 0);
    tick(); #1;
    chk("adel_c_we", bus.cp0_we, 1);
    chk("adel_c_code", bus.cp0_exc_code, 32'h04);
    chk("adel_c_epc", bus.cp0_epc, 32'hbfc00200);
    chk("adel_c_bd", bus.cp0_bd, 1);
    chk("adel_c_badv_we", bus.cp0_badv_we, 1);
    chk("adel_c_badv", bus.cp0_badvaddr, 32'h00000003);
    tick(); #1;
    chk("adel_r_badv_we", bus.cp0_badv_we, 0);
    chk("adel_r_rpc", bus.redirect_pc, 32'hbfc00380);
    tick(); #1;
    chk("adel_i_rv", bus.redirect_valid, 0);

    // ERET alone
    bus.m_valid = 1'b1;
    bus.eret_m  = 1'b1;
    bus.epc_in  = 32'hbfc00300;
    bus.pc_m    = 32'hbfc00010;
    #1;
    chk("eret_t_stall", bus.stall_all, 1);
    tick(); clear_in(); #1;
    chk("eret_c_eret", bus.cp0_eret, 1);
    chk("eret_c_we", bus.cp0_we, 0);
    chk("eret_c_badv_we", bus.cp0_badv_we, 0);
    chk("eret_c_flush", bus.flush_all, 1);
    tick(); #1;
    chk("eret_r_eret", bus.cp0_eret, 0);
    chk("eret_r_rv", bus.redirect_valid, 1);
    chk("eret_r_rpc", bus.redirect_pc, 32'hbfc00300);
    tick(); #1;

    // ERET together with RI: exception wins
    exc_ev(5'h0a, 1'b0, 32'hbfc00020);
    bus.eret_m = 1'b1;
    bus.epc_in = 32'hbfc00300;
    tick(); clear_in(); #1;
    chk("eexc_c_we", bus.cp0_we, 1);
    chk("eexc_c_eret", bus.cp0_eret, 0);
    chk("eexc_c_code", bus.cp0_exc_code, 32'h0a);
    tick(); #1;
    chk("eexc_r_rpc", bus.redirect_pc, 32'hbfc00380);
    tick(); #1;

    // Interrupt beats syscall
    exc_ev(5'h08, 1'b0, 32'hbfc00030);
    bus.int_pending = 1'b1;
    tick(); clear_in(); #1;
    chk("int_c_we", bus.cp0_we, 1);
    chk("int_c_code", bus.cp0_exc_code, 32'h00);
    chk("int_c_epc", bus.cp0_epc, 32'hbfc00030);
    tick(); #1;
    tick(); #1;

    // No event without m_valid
    bus.int_pending = 1'b1;
    bus.exc_valid_m = 1'b1;
    bus.exc_code_m  = 5'h08;
    #1;
    chk("nom_stall", bus.stall_all, 0);
    tick(); clear_in(); #1;
    chk("nom_we", bus.cp0_we, 0);
    chk("nom_stall2", bus.stall_all, 0);
    chk("nom_flush", bus.flush_all, 0);

    // Redirect handshake held off for 4 cycles
    bus.redirect_ready = 1'b0;
    we_seen = 0;
    exc_ev(5'h0c, 1'b0, 32'hbfc00400);
    #1;
    we_seen += int'(bus.cp0_we);
    tick(); clear_in(); #1;
    we_seen += int'(bus.cp0_we);
    chk("hs_c_we", bus.cp0_we, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      we_seen += int'(bus.cp0_we);
      chk("hs_w_rv", bus.redirect_valid, 1);
      chk("hs_w_rpc", bus.redirect_pc, 32'hbfc00380);
      chk("hs_w_stall", bus.stall_all, 1);
    end
    tick(); bus.redirect_ready = 1'b1; #1;
    we_seen += int'(bus.cp0_we);
    chk("hs_5_rv", bus.redirect_valid, 1);
    chk("hs_5_rpc", bus.redirect_pc, 32'hbfc00380);
    chk("hs_5_stall", bus.stall_all, 1);
    tick(); #1;
    we_seen += int'(bus.cp0_we);
    chk("hs_i_rv", bus.redirect_valid, 0);
    chk("hs_i_stall", bus.stall_all, 0);
    chk("hs_we_count", we_seen, 1);

    // New event in the first IDLE cycle after REDIRECT
    exc_ev(5'h09, 1'b0, 32'hbfc00500);
    #1;
    chk("b2b_t_stall", bus.stall_all, 1);
    tick(); clear_in(); #1;
    chk("b2b_c_we", bus.cp0_we, 1);
    chk("b2b_c_code", bus.cp0_exc_code, 32'h09);
    chk("b2b_c_epc", bus.cp0_epc, 32'hbfc00500);
    tick(); #1;
    tick(); #1;

    // Reset while draining aborts without a CP0 write
    exc_ev(5'h05, 1'b0, 32'hbfc00600);
    bus.ibus_busy = 1'b1;
    tick(); clear_in(); bus.ibus_busy = 1'b1; resetn = 1'b0; #1;
    chk("rd_d_stall", bus.stall_all, 1);
    tick(); resetn = 1'b1; bus.ibus_busy = 1'b0; #1;
    chk("rd_stall", bus.stall_all, 0);
    chk("rd_flush", bus.flush_all, 0);
    chk("rd_we", bus.cp0_we, 0);
    chk("rd_rv", bus.redirect_valid, 0);
    chk("rd_rpc", bus.redirect_pc, 32'h0);
    chk("rd_epc", bus.cp0_epc, 32'h0);
    tick(); #1;
    chk("rd_we2", bus.cp0_we, 0);
    chk("rd_stall2", bus.stall_all, 0);
    tick(); #1;
    chk("rd_we3", bus.cp0_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
